// File: rtl/mult_acc.sv
`default_nettype none
// ============================================================================
//  Module      : mult_acc
//  Description : Burst accumulator for double-width products. Each burst
//                sums len products {hi,lo} modulo 2^(2*WIDTH), keeps a
//                sticky carry-out flag, and presents the result with a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_acc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     lo,
  input  logic [WIDTH-1:0]     hi,
  input  logic [CNT_W-1:0]     len,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [2*WIDTH-1:0]   sum,
  output logic                 overflow,
  output logic                 valid_out,
  input  logic                 ready_in
);

  localparam int               c_ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q;

  // Datapath registers and their next-state values
  logic [c_ACC_W-1:0]   acc_q,  acc_d;
  logic                 ovf_q,  ovf_d;
  logic [CNT_W-1:0]     rem_q,  rem_d;

  // Registered outputs
  logic                 ready_out_q;
  logic                 valid_out_q;
  logic [c_ACC_W-1:0]   sum_q;
  logic                 overflow_q;

  logic                 w_accept;
  logic                 w_enter_done;
  logic [c_ACC_W-1:0]   w_prod;
  logic [c_ACC_W:0]     w_sum_ext;

  assign w_accept  = valid_in & ready_out_q;
  assign w_prod    = {hi, lo};
  // One extra bit captures the carry out of the accumulator width
  assign w_sum_ext = {1'b0, acc_q} + {1'b0, w_prod};

  assign ready_out = ready_out_q;
  assign valid_out = valid_out_q;
  assign sum       = sum_q;
  assign overflow  = overflow_q;

  // Next accumulator, overflow flag and beat counter for the current beat
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    rem_d = rem_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          acc_d = w_prod;
          ovf_d = 1'b0;
          // A zero length is treated as a single-beat burst
          rem_d = (len == '0) ? '0 : (len - c_ONE);
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          acc_d = w_sum_ext[c_ACC_W-1:0];
          ovf_d = ovf_q | w_sum_ext[c_ACC_W];
          rem_d = (rem_q == '0) ? '0 : (rem_q - c_ONE);
        end
      end
      default: begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        rem_d = rem_q;
      end
    endcase
  end

  // Detect the beat that completes the burst (first beat or counted-down last)
  always_comb begin
    w_enter_done = 1'b0;
    case (state_q)
      S_IDLE:  w_enter_done = w_accept && (rem_d == '0);
      // rem_q of zero cannot occur in ACCUM; treating it as last avoids a hang
      S_ACCUM: w_enter_done = w_accept && (rem_q <= c_ONE);
      default: w_enter_done = 1'b0;
    endcase
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      rem_q       <= '0;
      ready_out_q <= 1'b1;
      valid_out_q <= 1'b0;
      sum_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      rem_q <= rem_d;
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (w_enter_done) begin
            state_q     <= S_DONE;
            ready_out_q <= 1'b0;
            valid_out_q <= 1'b1;
            sum_q       <= acc_d;
            overflow_q  <= ovf_d;
          end else if (w_accept) begin
            state_q     <= S_ACCUM;
          end
        end
        S_DONE: begin
          // Result is held stable until downstream takes it
          if (ready_in) begin
            state_q     <= S_IDLE;
            ready_out_q <= 1'b1;
            valid_out_q <= 1'b0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
          end
        end
        default: begin
          // Unused encoding: recover to an idle, empty result
          state_q     <= S_IDLE;
          ready_out_q <= 1'b1;
          valid_out_q <= 1'b0;
          sum_q       <= '0;
          overflow_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mult_acc.md
MULT_ACC -- requirements
Module: mult_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of each product half (lo, hi).
REQ-002 SHALL have parameter CNT_W, default 8: width of the burst-length input.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port lo, input, WIDTH: low half of the incoming product.
REQ-006 SHALL have port hi, input, WIDTH: high half of the incoming product.
REQ-007 SHALL have port len, input, CNT_W: number of products per accumulation; sampled only on the first beat of a burst.
REQ-008 SHALL have port valid_in, input, 1: upstream product valid.
REQ-009 SHALL have port ready_out, output, 1: block accepts a product this cycle.
REQ-010 SHALL have port sum, output, 2*WIDTH: accumulated result.
REQ-011 SHALL have port overflow, output, 1: sticky flag, set when any addition in the burst carried out of 2*WIDTH bits.
REQ-012 SHALL have port valid_out, output, 1: sum/overflow valid.
REQ-013 SHALL have port ready_in, input, 1: downstream accepts the result.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE; any unused encoding SHALL return to IDLE on the next edge.
REQ-015 A beat SHALL be accepted only when valid_in=1 and ready_out=1 at the same edge.
REQ-016 ready_out SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-017 IDLE, on an accepted beat: load acc={hi,lo}, clear overflow, load remaining=len-1 (len=0 treated as 1).
REQ-018 IDLE transition: go to DONE if remaining is 0, else go to ACCUM.
REQ-019 ACCUM, on an accepted beat: acc <= acc + {hi,lo} modulo 2^(2*WIDTH); overflow <= overflow OR carry-out; remaining decrements.
REQ-020 ACCUM, when the accepted beat has remaining=1 before the decrement: go to DONE.
REQ-021 ACCUM with valid_in=0 SHALL hold all state; bubbles of any length between beats are allowed.
REQ-022 DONE: valid_out=1, sum=acc and overflow=flag, all held stable until handshake.
REQ-023 DONE: on ready_in=1, go to IDLE; else stay in DONE.
REQ-024 In states other than DONE, valid_out, sum and overflow SHALL be 0.
REQ-025 Latency: valid_out SHALL rise on the cycle after the edge that accepted the last beat.
REQ-026 Throughput: one beat per cycle within a burst, plus at least one non-accepting cycle (DONE) between bursts.
REQ-027 len changes after the first beat SHALL not affect the burst in progress.
REQ-028 ready_in is ignored outside DONE; valid_in is ignored in DONE, and upstream must hold the product until ready_out=1.

Reset
REQ-029 When rst=1 at an edge: state=IDLE, acc=0, overflow flag=0, remaining=0, regardless of current state; this takes priority over any handshake at the same edge.
REQ-030 Output values while in reset and on the following cycle: ready_out=1, valid_out=0, sum=0, overflow=0.
REQ-031 Reset asserted mid-burst or in DONE SHALL discard the partial or held result; no valid_out SHALL appear for it.

Verification (WIDTH=8, CNT_W=4)
REQ-032 Single-beat burst: len=1, {hi,lo}=0x0102 -> valid_out next cycle, sum=0x0102, overflow=0.
REQ-033 Burst with bubbles: len=3, products 0x0010, 0x0020, 0x0030, with 2 idle cycles between beats -> sum=0x0060, valid_out exactly one cycle after the third accept.
REQ-034 Overflow: len=2, products 0xFFFF and 0x0002 -> sum=0x0001, overflow=1; the next burst len=1, product 0x0005 -> overflow=0.
REQ-035 Backpressure: ready_in=0 for 5 cycles in DONE while valid_in=1 -> ready_out=0 and sum stable throughout; after ready_in=1, IDLE with ready_out=1 on the next cycle.
REQ-036 Reset mid-burst: len=4 with 2 beats accepted, then rst=1 for one cycle -> valid_out stays 0; a new len=1 burst with product 0x0007 -> sum=0x0007.
REQ-037 Edge case: len=0 with product 0x0009 -> behaves as len=1, sum=0x0009.
